rc5_key_expand: RTL
===================

Name: rc5_key_expand

Overview:
- RC5-16 key-schedule engine.
- Expands the 128-bit user key into the subkey table S[0..33] of 16-bit words consumed by the round datapath of the encrypt/decrypt core.
- Sits directly upstream of that core.
- Sequential: one table-init word per cycle, then one mixing iteration per cycle.
- Presents the finished table on a flat bus with a valid flag.

Parameters:
- W, 16, word width in bits (fixed for RC5-16; not overridable in practice).
- MAX_ROUNDS, 16, maximum round count supported.
- KEY_WORDS, 8, number of 16-bit key words (128-bit key).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  request expansion; sampled only in IDLE
- num_rounds  in  5  round count r (not 0-indexed); values >16 clamp to 16
- key  in  128  user key; L[j] = key[16j+15:16j], j=0..7
- busy  out  1  high from cycle after start acceptance until done cycle inclusive
- done  out  1  one-cycle pulse when table complete
- sk_valid  out  1  table valid; held until next start or reset
- subkeys  out  544  S[i] at bits [16i+15:16i], i=0..33

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; busy=0, done=0, sk_valid=0; all S, L, A, B and counters cleared; subkeys=0. Reset mid-operation aborts immediately with the same values.
- Start capture: start=1 in IDLE at cycle N latches key into L[0..7] and latches r. Derived quantities:
  - t = 2(r+1), so 2..34.
  - nmix = 3*max(t,8).
  - sk_valid drops at cycle N+1.
  - S[t..33] are zeroed.
- start while not IDLE is ignored; key/num_rounds changes after capture are ignored.
- States: IDLE -> INIT -> MIX -> DONE -> IDLE.
- INIT, cycles N+1..N+t: S[k] = P16 + k*Q16 mod 2^16, one word per cycle (k=0..t-1).
  - P16=0xB7E1, Q16=0x9E37.
  - Implement as a running accumulator, not a multiplier.
- MIX, cycles N+t+1..N+t+nmix: one iteration per cycle, with A=B=i=j=0 on entry:
  - Anew = ROTL(S[i]+A+B, 3); S[i] = Anew.
  - Bnew = ROTL(L[j]+Anew+B, (Anew+B)[3:0]); L[j] = Bnew.
  - A = Anew, B = Bnew.
  - i = (i+1==t) ? 0 : i+1.
  - j = (j+1) mod 8.
  - All additions are mod 2^16. The B update uses this iteration's Anew (same cycle, combinational chain).
- DONE, cycle N+t+nmix+1: done=1, sk_valid=1, busy=1. The next cycle returns to IDLE with busy=0.
- Total latency start→done = t+nmix+1 cycles.
  - r=0: t=2, nmix=24, done at N+27.
  - r=12: t=26, nmix=78, done at N+105.
  - r=16: t=34, nmix=102, done at N+137.
- Back-to-back: start sampled in the IDLE cycle after DONE is accepted normally.
- subkeys is driven straight from the S registers and is meaningful only while sk_valid=1.

Decomposition:
- rc5_pkg holds:
  - W, MAX_ROUNDS, MAX_SUBKEYS=34, KEY_WORDS=8, P16, Q16.
  - State enum {IDLE, INIT, MIX, DONE}.
  - Helper function for nmix.
- Reuse the existing rotl sub-module (data_i, n_i[3:0] used, data_o) for the variable rotate.
- The rotate-by-3 is constant wiring; no separate module.

Test Plan:
- Reset mid-MIX (assert rst at N+10) -> next cycle busy=0, done=0, sk_valid=0, subkeys=0; a subsequent start completes normally.
- r=0, key=0, start at N -> done exactly at N+27; internal S[0]=0xBF0D and B=0xB7E1 after first MIX cycle; S[2..33]=0; final table matches C reference model.
- r=12, key=0x0F0E0D0C0B0A09080706050403020100 -> done at N+105; S[0..25] match reference model; S[26..33]=0.
- r=31 (clamp), any key -> behaves identically to r=16, done at N+137, all 34 words match model.
- start pulsed again at N+5 and key changed mid-run -> ignored; result equals first-key model; a second start the cycle after DONE is accepted, sk_valid low from the next cycle.
- Randomized r∈[0,16] and key, 200 runs -> every table and done cycle match the model; done is exactly one cycle wide each run.

Source files
------------

// File: rtl/rc5_pkg.sv
// rc5_pkg: shared constants, state encoding and round-count helpers for the RC5-16 key schedule
package rc5_pkg;

   localparam int W           = 16;
   localparam int MAX_ROUNDS  = 16;
   localparam int MAX_SUBKEYS = 34;
   localparam int KEY_WORDS   = 8;

   localparam logic [W-1:0] P16 = 16'hB7E1;
   localparam logic [W-1:0] Q16 = 16'h9E37;

   typedef enum logic [1:0] {IDLE, INIT, MIX, DONE} state_t;

   // table length t = 2(r+1) after clamping r to the supported maximum
   function automatic logic [5:0] t_of(input logic [4:0] r);
      logic [4:0] rc;
      rc = (r > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : r;
      return {rc, 1'b0} + 6'd2;
   endfunction

   // mixing iterations: three passes over the longer of S and L
   function automatic logic [6:0] nmix_of(input logic [5:0] t);
      logic [5:0] m;
      m = (t < 6'd8) ? 6'd8 : t;
      return {1'b0, m} + {m, 1'b0};
   endfunction

endpackage

// File: rtl/rc5_key_expand_if.sv
// rc5_key_expand_if: request/result bundle between the key-schedule engine and its user
interface rc5_key_expand_if;
   import rc5_pkg::*;

   logic                         start;
   logic [4:0]                   num_rounds;
   logic [KEY_WORDS*W-1:0]       key;
   logic                         busy;
   logic                         done;
   logic                         sk_valid;
   logic [MAX_SUBKEYS*W-1:0]     subkeys;

   modport master (
      output start, num_rounds, key,
      input  busy, done, sk_valid, subkeys
   );

   modport slave (
      input  start, num_rounds, key,
      output busy, done, sk_valid, subkeys
   );

endinterface

// File: rtl/rotl.sv
// rotl: variable left rotate of a word by 0..15 bits
module rotl #(
   parameter int W = 16
) (
   input  logic [W-1:0] data_i,
   input  logic [3:0]   n_i,
   output logic [W-1:0] data_o
);

   logic [2*W-1:0] dbl;

   // shifting the doubled word leaves the rotated value in the upper half
   always_comb begin
      dbl    = {data_i, data_i} << n_i;
      data_o = dbl[2*W-1:W];
   end

endmodule

// File: rtl/rc5_key_expand.sv
// rc5_key_expand: sequential RC5-16 key schedule producing S[0..33] from a 128-bit key
module rc5_key_expand
   import rc5_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   rc5_key_expand_if.slave  bus
);

   state_t       state_q, state_d;
   logic [W-1:0] s_q [MAX_SUBKEYS];
   logic [W-1:0] s_d [MAX_SUBKEYS];
   logic [W-1:0] l_q [KEY_WORDS];
   logic [W-1:0] l_d [KEY_WORDS];
   logic [W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic [5:0]   i_q, i_d, t_q, t_d;
   logic [2:0]   j_q, j_d;
   logic [6:0]   cnt_q, cnt_d, nmix_q, nmix_d;
   logic         valid_q, valid_d;
   logic [W-1:0] sum_a, a_new, ab, sum_b, b_new;

   rotl #(.W(W)) u_rotl (
      .data_i (sum_b),
      .n_i    (ab[3:0]),
      .data_o (b_new)
   );

   // one mixing step: A rotates by a constant 3, B by the low nibble of A+B
   always_comb begin
      sum_a = s_q[i_q] + a_q + b_q;
      a_new = {sum_a[W-4:0], sum_a[W-1:W-3]};
      ab    = a_new + b_q;
      sum_b = l_q[j_q] + ab;
   end

   // next-state logic: capture, table init via running accumulator, mixing, completion
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      l_d     = l_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      i_d     = i_q;
      j_d     = j_q;
      t_d     = t_q;
      cnt_d   = cnt_q;
      nmix_d  = nmix_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = INIT;
            valid_d = 1'b0;
            t_d     = t_of(bus.num_rounds);
            nmix_d  = nmix_of(t_d);
            acc_d   = P16;
            i_d     = '0;
            for (int k = 0; k < MAX_SUBKEYS; k++) s_d[k] = '0;
            for (int k = 0; k < KEY_WORDS; k++) l_d[k] = bus.key[W*k +: W];
         end
         INIT: begin
            s_d[i_q] = acc_q;
            acc_d    = acc_q + Q16;
            i_d      = i_q + 6'd1;
            if (i_q == t_q - 6'd1) begin
               state_d = MIX;
               i_d     = '0;
               j_d     = '0;
               a_d     = '0;
               b_d     = '0;
               cnt_d   = '0;
            end
         end
         MIX: begin
            s_d[i_q] = a_new;
            l_d[j_q] = b_new;
            a_d      = a_new;
            b_d      = b_new;
            i_d      = (i_q + 6'd1 == t_q) ? 6'd0 : i_q + 6'd1;
            j_d      = j_q + 3'd1;
            cnt_d    = cnt_q + 7'd1;
            if (cnt_q == nmix_q - 7'd1) begin
               state_d = DONE;
               valid_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers; active-low synchronous reset clears everything
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         s_q     <= '{default: '0};
         l_q     <= '{default: '0};
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         t_q     <= '0;
         cnt_q   <= '0;
         nmix_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         l_q     <= l_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         i_q     <= i_d;
         j_q     <= j_d;
         t_q     <= t_d;
         cnt_q   <= cnt_d;
         nmix_q  <= nmix_d;
         valid_q <= valid_d;
      end
   end

   assign bus.busy     = state_q != IDLE;
   assign bus.done     = state_q == DONE;
   assign bus.sk_valid = valid_q;

   for (genvar g = 0; g < MAX_SUBKEYS; g++) begin : g_sk
      assign bus.subkeys[W*g +: W] = s_q[g];
   end

endmodule
